sysid_boot_checker: RTL and testbench

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two read-only words: system ID (address 0) and build timestamp (address 1). After reset, and again on each `start` pulse, it reads both words, compares them with compile-time expected values and reports match, mismatch or timeout. The host CPU or board-level LEDs use its status outputs to reject a mismatched FPGA image before software runs.

---
 rtl/sysid_pkg.sv | 21 ++
 rtl/sysid_boot_checker_if.sv | 24 ++
 rtl/sysid_wait_timer.sv | 27 ++
 rtl/sysid_boot_checker.sv | 149 ++++++++++++++
 tb/tb_sysid_boot_checker.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

    // Checker sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        GAP,
        CHECK,
        DONE
    } sysid_state_t;

    // Word addresses inside the system-ID slave.
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Data width of the system-ID slave.
    localparam int SYSID_DW = 32;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read channel between the boot checker and the system-ID slave.
interface sysid_boot_checker_if;
    import sysid_pkg::*;

    logic                avm_address;
    logic                avm_read;
    logic [SYSID_DW-1:0] avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/sysid_wait_timer.sv
// 16-bit saturating stall counter; expired flags count == LIMIT.
module sysid_wait_timer #(
    parameter int unsigned LIMIT = 254
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] count;

    // Count stall cycles, clear on request, stick at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == LIMIT[15:0]);

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the system-ID and build-timestamp words after reset (and on each
// start pulse), compares them with the expected image values and reports
// match / mismatch / timeout.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [SYSID_DW-1:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [SYSID_DW-1:0] EXPECTED_TS    = 32'd1461087867,
    parameter bit                  CHECK_TS       = 1'b1,
    parameter int unsigned         TIMEOUT_CYCLES = 255,
    parameter int unsigned         RETRIES        = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    sysid_boot_checker_if.master avm,
    output logic [SYSID_DW-1:0] id_value,
    output logic [SYSID_DW-1:0] ts_value,
    output logic                busy,
    output logic                done,
    output logic                match,
    output logic                timeout_err
);

    sysid_state_t state, next_state;
    logic         start_pend;
    logic [3:0]   retry_cnt;
    logic         ret_ts;
    logic         addr_q;
    logic         rd_active;
    logic         expired;
    logic         retry_ok;
    logic         start_chk;

    assign rd_active = (state == RD_ID) || (state == RD_TS);
    assign retry_ok  = (retry_cnt < RETRIES[3:0]);

    // The timer limit is one below TIMEOUT_CYCLES so the timeout decision is
    // taken during the stall cycle that brings the count to TIMEOUT_CYCLES;
    // a failed attempt therefore holds avm_read for exactly TIMEOUT_CYCLES.
    sysid_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (!rd_active || !avm.avm_waitrequest),
        .en      (rd_active && avm.avm_waitrequest),
        .expired (expired)
    );

    // Bus strobe decodes from the state register; address is a held register.
    assign avm.avm_read    = rd_active;
    assign avm.avm_address = addr_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and check-start strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_state = state;
        start_chk  = 1'b0;
        case (state)
            IDLE: begin
                if (start_pend || start) begin
                    next_state = RD_ID;
                    start_chk  = 1'b1;
                end
            end
            RD_ID: begin
                if (!avm.avm_waitrequest) begin
                    next_state = RD_TS;
                end else if (expired) begin
                    next_state = retry_ok ? GAP : DONE;
                end
            end
            RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    next_state = CHECK;
                end else if (expired) begin
                    next_state = retry_ok ? GAP : DONE;
                end
            end
            GAP:     next_state = ret_ts ? RD_TS : RD_ID;
            CHECK:   next_state = DONE;
            DONE: begin
                if (start) begin
                    next_state = RD_ID;
                    start_chk  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture registers, retry bookkeeping, address and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // here samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            start_pend  <= 1'b1;
            retry_cnt   <= '0;
            ret_ts      <= 1'b0;
            addr_q      <= SYSID_ADDR_ID;
            id_value    <= '0;
            ts_value    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (start_chk) begin
                start_pend  <= 1'b0;
                retry_cnt   <= '0;
                match       <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (rd_active && !avm.avm_waitrequest) begin
                if (state == RD_ID) id_value <= avm.avm_readdata;
                else                ts_value <= avm.avm_readdata;
                retry_cnt <= '0;
            end else if (rd_active && expired) begin
                if (retry_ok) begin
                    retry_cnt <= retry_cnt + 4'd1;
                    ret_ts    <= (state == RD_TS);
                end else begin
                    timeout_err <= 1'b1;
                end
            end
            if (state == CHECK) begin
                match <= (id_value == EXPECTED_ID) &&
                         (!CHECK_TS || (ts_value == EXPECTED_TS));
            end
            if (next_state == RD_ID)      addr_q <= SYSID_ADDR_ID;
            else if (next_state == RD_TS) addr_q <= SYSID_ADDR_TS;
            busy <= (next_state == RD_ID) || (next_state == RD_TS) ||
                    (next_state == GAP)   || (next_state == CHECK);
            done <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench: two checkers (timestamp compared / not compared) share
// one scripted or random slave; a transaction-level model predicts every
// output each cycle, and directed runs pin latencies and read counts.
module tb_sysid_boot_checker;
    import sysid_pkg::*;

    localparam int          T      = 4;
    localparam int          R      = 2;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1461087867;

    logic        clock = 1'b0;
    logic        reset_n, start, wr;
    logic [31:0] id_word, ts_word;
    logic [31:0] id0, ts0, id1, ts1;
    logic        busy0, done0, match0, terr0;
    logic        busy1, done1, match1, terr1;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clock = ~clock;

    sysid_boot_checker_if bus0 ();
    sysid_boot_checker_if bus1 ();

    assign bus0.avm_waitrequest = wr;
    assign bus1.avm_waitrequest = wr;
    assign bus0.avm_readdata    = bus0.avm_address ? ts_word : id_word;
    assign bus1.avm_readdata    = bus1.avm_address ? ts_word : id_word;

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
        .TIMEOUT_CYCLES(T), .RETRIES(R)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .avm(bus0),
        .id_value(id0), .ts_value(ts0), .busy(busy0), .done(done0),
        .match(match0), .timeout_err(terr0)
    );

    sysid_boot_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
        .TIMEOUT_CYCLES(T), .RETRIES(R)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .avm(bus1),
        .id_value(id1), .ts_value(ts1), .busy(busy1), .done(done1),
        .match(match1), .timeout_err(terr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which word is being fetched, how long the
    // current attempt has stalled, how many retries were spent.
    bit          m_act, m_done, m_pend, m_gap, m_addr;
    bit          m_match0, m_match1, m_terr;
    int          m_word, m_waits, m_tries;
    logic [31:0] m_id, m_ts;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_act <= 0; m_done <= 0; m_pend <= 1; m_gap <= 0; m_addr <= 0;
            m_match0 <= 0; m_match1 <= 0; m_terr <= 0;
            m_word <= 0; m_waits <= 0; m_tries <= 0; m_id <= '0; m_ts <= '0;
        end else if (m_act) begin
            if (m_gap) begin
                m_gap <= 0;
            end else if (m_word == 2) begin
                m_match0 <= (m_id == EXP_ID) && (m_ts == EXP_TS);
                m_match1 <= (m_id == EXP_ID);
                m_done   <= 1;
                m_act    <= 0;
            end else if (!wr) begin
                if (m_word == 0) begin
                    m_id   <= id_word;
                    m_addr <= 1;
                end else begin
                    m_ts <= ts_word;
                end
                m_word  <= m_word + 1;
                m_waits <= 0;
                m_tries <= 0;
            end else if (m_waits + 1 == T) begin
                m_waits <= 0;
                if (m_tries < R) begin
                    m_tries <= m_tries + 1;
                    m_gap   <= 1;
                end else begin
                    m_terr <= 1;
                    m_done <= 1;
                    m_act  <= 0;
                end
            end else begin
                m_waits <= m_waits + 1;
            end
        end else if (start || (m_pend && !m_done)) begin
            m_pend <= 0; m_done <= 0; m_match0 <= 0; m_match1 <= 0; m_terr <= 0;
            m_act <= 1; m_word <= 0; m_gap <= 0; m_waits <= 0; m_tries <= 0;
            m_addr <= 0;
        end
    end

    // Per-cycle comparison of both checkers against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("read0", 32'(bus0.avm_read), 32'(m_act && !m_gap && m_word < 2));
            check("read1", 32'(bus1.avm_read), 32'(m_act && !m_gap && m_word < 2));
            check("addr0", 32'(bus0.avm_address), 32'(m_addr));
            check("addr1", 32'(bus1.avm_address), 32'(m_addr));
            check("busy0", 32'(busy0), 32'(m_act));
            check("busy1", 32'(busy1), 32'(m_act));
            check("done0", 32'(done0), 32'(m_done));
            check("done1", 32'(done1), 32'(m_done));
            check("terr0", 32'(terr0), 32'(m_terr));
            check("terr1", 32'(terr1), 32'(m_terr));
            check("match0", 32'(match0), 32'(m_match0));
            check("match1", 32'(match1), 32'(m_match1));
            check("id0", id0, m_id);
            check("id1", id1, m_id);
            check("ts0", ts0, m_ts);
            check("ts1", ts1, m_ts);
        end
    end

    // Waitrequest for the cycle following edge k of a check.
    function automatic logic wr_pattern(input int mode, input int k);
        case (mode)
            1:       return (k <= 3);
            2:       return 1'b1;
            3:       return ($urandom_range(0, 3) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Runs one check from the current negedge+1 until done, counting edges
    // (edge 1 = first edge that can launch the check) and read cycles.
    task automatic run_check(input int mode, input bit do_start, input int inject_at,
                             input string tag, output int edges, output int reads);
        edges = 0;
        reads = 0;
        start = do_start;
        wr    = wr_pattern(mode, 0);
        while (edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            #1;
            start = (edges == inject_at);
            if (bus0.avm_read) reads++;
            if (done0) break;
            wr = wr_pattern(mode, edges);
        end
        start = 1'b0;
        wr    = 1'b0;
        check({tag, "_done_reached"}, 32'(done0), 32'd1);
    endtask

    int e, r;

    initial begin
        reset_n = 1'b1; start = 1'b0; wr = 1'b0;
        id_word = EXP_ID; ts_word = EXP_TS;
        #3 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clock); @(negedge clock);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_read", 32'(bus0.avm_read), 32'd0);
        check("rst_id", id0, 32'd0);
        #1 reset_n = 1'b1;

        // Automatic check after reset, zero-wait slave.
        run_check(0, 1'b0, 0, "auto", e, r);
        check("auto_edges", e, 4);
        check("auto_reads", r, 2);
        check("auto_match", 32'(match0), 32'd1);
        check("auto_terr", 32'(terr0), 32'd0);
        check("auto_ts", ts0, EXP_TS);

        // Wrong ID word.
        id_word = 32'h0000_0001;
        run_check(0, 1'b1, 0, "badid", e, r);
        check("badid_edges", e, 4);
        check("badid_match0", 32'(match0), 32'd0);
        check("badid_match1", 32'(match1), 32'd0);
        check("badid_id", id0, 32'h0000_0001);

        // Wrong timestamp: only the timestamp-checking instance rejects it.
        id_word = EXP_ID; ts_word = 32'd12345;
        run_check(0, 1'b1, 0, "badts", e, r);
        check("badts_match0", 32'(match0), 32'd0);
        check("badts_match1", 32'(match1), 32'd1);
        check("badts_ts1", ts1, 32'd12345);

        // Three stall cycles on the ID read.
        ts_word = EXP_TS;
        run_check(1, 1'b1, 0, "stall3", e, r);
        check("stall3_edges", e, 7);
        check("stall3_reads", r, 5);
        check("stall3_match", 32'(match0), 32'd1);

        // Slave never answers: three attempts of T cycles, two GAP cycles.
        run_check(2, 1'b1, 0, "stuck", e, r);
        check("stuck_edges", e, 3 * T + 2 + 1);
        check("stuck_reads", r, 3 * T);
        check("stuck_terr0", 32'(terr0), 32'd1);
        check("stuck_terr1", 32'(terr1), 32'd1);
        check("stuck_match", 32'(match0), 32'd0);

        // Start pulse during RD_TS is ignored and not queued.
        run_check(0, 1'b1, 2, "busystart", e, r);
        check("busystart_edges", e, 4);
        check("busystart_reads", r, 2);
        check("busystart_terr", 32'(terr0), 32'd0);
        repeat (3) @(negedge clock);
        check("busystart_hold", 32'(done0), 32'd1);
        #1;

        // Randomised words, stalls, idle gaps and stray start pulses.
        for (int i = 0; i < 25; i++) begin
            id_word = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_ID;
            ts_word = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_TS;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clock);
                #1;
            end
            run_check(3, 1'b1, $urandom_range(0, 8), "rand", e, r);
        end

        // Leave non-zero captures, then reset in the middle of a read.
        id_word = 32'hDEAD_0001; ts_word = 32'hBEEF_0002;
        run_check(0, 1'b1, 0, "prerst", e, r);
        id_word = EXP_ID; ts_word = EXP_TS;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1 start = 1'b0;
        check("midrst_read_before", 32'(bus0.avm_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_read", 32'(bus0.avm_read), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_id", id0, 32'd0);
        check("midrst_ts", ts0, 32'd0);
        check("midrst_addr", 32'(bus0.avm_address), 32'd0);
        @(negedge clock); @(negedge clock);
        #1 reset_n = 1'b1;
        run_check(0, 1'b0, 0, "postrst", e, r);
        check("postrst_edges", e, 4);
        check("postrst_match", 32'(match0), 32'd1);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
